// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Consumer end of the hazard-unit handshake. Turns freeze/flush requests and
// the cache hit signals into PC and pipeline-latch enable/bubble controls,
// tracks a valid bit per latch and sequences processor halt.
//
// Optional build macro: PIPE_PERF_CNT_EN adds the stall_cnt output and a
// saturating stall-cycle counter of width CNT_W.
//
// Ports:
//   CLK        system clock, all state updates on rising edge
//   nRST       synchronous active-low reset
//   ihit       instruction fetch returned this cycle
//   dhit       data access completed this cycle
//   freeze     hazard_unit load-use stall request
//   flush      hazard_unit branch/jump redirect
//   mem_dREN   EX/MEM latch holds a load
//   mem_dWEN   EX/MEM latch holds a store
//   mem_halt   EX/MEM latch holds HALT
//   pc_en      PC register load enable
//   ifid_en, idex_en, exmem_en, memwb_en   latch load enables
//   ifid_bub, idex_bub                     load a NOP into that latch
//   valid      [0]=IF/ID .. [3]=MEM/WB valid bits
//   mem_req    EX/MEM holds a valid load/store
//   halted     processor halted (registered)
//   stall_cnt  saturating stall-cycle count (PIPE_PERF_CNT_EN only)
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal operation, hazard priority dstall > flush > freeze > ~ihit
// HALTED | HALT reached MEM/WB; everything frozen until reset

module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             freeze,
    input  logic             flush,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_bub,
    output logic             idex_bub,
    output logic [3:0]       valid,
    output logic             mem_req,
    output logic             halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] valid_q, valid_d;
    logic       dstall;

    assign mem_req = valid_q[2] & (mem_dREN | mem_dWEN);
    assign dstall  = mem_req & ~dhit;
    assign valid   = valid_q;
    assign halted  = (state_q == HALTED);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            valid_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        ifid_bub = 1'b0;
        idex_bub = 1'b0;

        if (nRST && state_q == RUN) begin
            if (dstall) begin
                // whole pipe holds; nothing moves, so a HALT in MEM waits too
                valid_d = valid_q;
            end else begin
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                if (flush) begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    ifid_bub = 1'b1;
                    idex_bub = 1'b1;
                    valid_d  = {valid_q[2], valid_q[1], 1'b0, 1'b0};
                end else if (freeze) begin
                    // IF/ID and PC hold the dependent instruction; bubble into EX
                    idex_en  = 1'b1;
                    idex_bub = 1'b1;
                    valid_d  = {valid_q[2], valid_q[1], 1'b0, valid_q[0]};
                end else if (!ihit) begin
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    ifid_bub = 1'b1;
                    valid_d  = {valid_q[2:0], 1'b0};
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    idex_en = 1'b1;
                    valid_d = {valid_q[2:0], 1'b1};
                end
                // EX/MEM always advances into MEM/WB when not data-stalled
                if (valid_q[2] && mem_halt) begin
                    state_d = HALTED;
                end
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_q;

    assign cnt_inc = (state_q == RUN) & (dstall | freeze | ~ihit);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (cnt_inc && cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cnt = cnt_q;
`else
    logic [CNT_W-1:0] unused_stall_cnt;
    assign unused_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    logic             CLK;
    logic             nRST;
    logic             ihit, dhit, freeze, flush;
    logic             mem_dREN, mem_dWEN, mem_halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_bub, idex_bub;
    logic [3:0]       valid;
    logic             mem_req, halted;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (ihit),
        .dhit     (dhit),
        .freeze   (freeze),
        .flush    (flush),
        .mem_dREN (mem_dREN),
        .mem_dWEN (mem_dWEN),
        .mem_halt (mem_halt),
        .pc_en    (pc_en),
        .ifid_en  (ifid_en),
        .idex_en  (idex_en),
        .exmem_en (exmem_en),
        .memwb_en (memwb_en),
        .ifid_bub (ifid_bub),
        .idex_bub (idex_bub),
        .valid    (valid),
        .mem_req  (mem_req),
        .halted   (halted)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       pc_en;
        logic [3:0] en;    // {memwb, exmem, idex, ifid}
        logic [1:0] bub;   // {idex, ifid}
        logic [3:0] valid;
        logic       mem_req;
        logic       halted;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [3:0]       m_valid;
    logic             m_halted;
    logic [CNT_W-1:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, obs, exp);
        end
    endtask

    // one clock: predict, push, sample at negedge, pop/compare, advance model
    task automatic tick();
        exp_t       e, g;
        logic [3:0] nv;
        logic       nh, inc, dst;
        e.valid   = m_valid;
        e.halted  = m_halted;
        e.cnt     = m_cnt;
        e.mem_req = m_valid[2] & (mem_dREN | mem_dWEN);
        dst       = e.mem_req & ~dhit;
        e.pc_en   = 1'b0;
        e.en      = 4'b0000;
        e.bub     = 2'b00;
        nv        = m_valid;
        nh        = m_halted;
        inc       = !m_halted && (dst || freeze || !ihit);
        if (nRST && !m_halted && !dst) begin
            if (flush) begin
                e.pc_en = 1'b1; e.en = 4'b1111; e.bub = 2'b11;
                nv = {m_valid[2], m_valid[1], 2'b00};
            end else if (freeze) begin
                e.en = 4'b1110; e.bub = 2'b10;
                nv = {m_valid[2], m_valid[1], 1'b0, m_valid[0]};
            end else if (!ihit) begin
                e.en = 4'b1111; e.bub = 2'b01;
                nv = {m_valid[2:0], 1'b0};
            end else begin
                e.pc_en = 1'b1; e.en = 4'b1111;
                nv = {m_valid[2:0], 1'b1};
            end
            if (m_valid[2] && mem_halt) nh = 1'b1;
        end
        sb_q.push_back(e);
        @(negedge CLK);
        g = sb_q.pop_front();
        chk("pc_en",   32'(pc_en), 32'(g.pc_en));
        chk("en",      32'({memwb_en, exmem_en, idex_en, ifid_en}), 32'(g.en));
        chk("bub",     32'({idex_bub, ifid_bub}), 32'(g.bub));
        chk("valid",   32'(valid), 32'(g.valid));
        chk("mem_req", 32'(mem_req), 32'(g.mem_req));
        chk("halted",  32'(halted), 32'(g.halted));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(g.cnt));
`endif
        if (!nRST) begin
            m_valid = 4'b0000; m_halted = 1'b0; m_cnt = '0;
        end else begin
            m_valid  = nv;
            m_halted = nh;
            if (inc && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic ih, input logic dh, input logic fz,
                         input logic fl, input logic rd, input logic wr, input logic hl);
        nRST = rst_n; ihit = ih; dhit = dh; freeze = fz; flush = fl;
        mem_dREN = rd; mem_dWEN = wr; mem_halt = hl;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        m_valid = 4'b0000; m_halted = 1'b0; m_cnt = '0;

        // reset state
        tick();
        // fill: 0000 -> 1111
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(4);
        chk("fill_valid", 32'(valid), 32'h0000000f);
        // data stall with load, 3 miss cycles then hit
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(3);
        dhit = 1'b1;
        run(1);
        // store miss, then hit
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run(2);
        dhit = 1'b1;
        run(1);
        // freeze one cycle
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run(1);
        freeze = 1'b0;
        run(3);
        // flush and freeze together
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run(1);
        flush = 1'b0; freeze = 1'b0;
        run(4);
        // fetch misses
        ihit = 1'b0;
        run(3);
        ihit = 1'b1;
        run(4);
        // randomized hazards, no halt
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, ($urandom_range(0, 9) < 8), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
            tick();
        end
        // reset mid-stall
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(4);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(2);
        nRST = 1'b0;
        run(1);
        nRST = 1'b1;
        run(2);
        // halt blocked by dstall, then taken on dhit
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        run(2);
        dhit = 1'b1;
        run(1);
        chk("halt_taken", 32'(halted), 32'h1);
        // halted: inputs ignored
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'(i), 1'(i >> 1), 1'(i >> 2), 1'(~i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        // reset mid-halt
        nRST = 1'b0;
        run(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(1);
        chk("post_halt_reset", 32'({halted, valid}), 32'h01);
`ifdef PIPE_PERF_CNT_EN
        // saturation of the stall counter
        nRST = 1'b0;
        run(1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(20);
        chk("cnt_sat", 32'(stall_cnt), 32'hf);
        // flush alone does not count
        nRST = 1'b0;
        run(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        chk("cnt_flush", 32'(stall_cnt), 32'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
